// File: rtl/mips32_run_monitor.sv
// mips32_run_monitor: run-control and performance monitor for the MIPS32 pipeline.
// Watches IF fetch and MEM store taps, counts cycles/fetches/stalls, detects
// program end (mailbox store, cycle timeout, halt opcode + drain) and latches a
// pass/fail verdict.
// Optional feature macro: MON_TRACE_EN builds a circular PC trace buffer.
module mips32_run_monitor #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter logic [31:0] HALT_INSN      = 32'hFFFF_FFFF,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_FFF0,
  parameter int unsigned TRACE_DEPTH    = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           PC_Enable,
  input  logic [31:0]                    Next_PC_IF,
  input  logic [31:0]                    Instruction_IF,
  input  logic                           MemWrite_MEM,
  input  logic [31:0]                    ALU_Result_MEM,
  input  logic [31:0]                    Write_Data_MUX_MEM,
  input  logic [$clog2(TRACE_DEPTH)-1:0] Trace_Idx,
  output logic [CNT_W-1:0]               Cycle_Count,
  output logic [CNT_W-1:0]               Fetch_Count,
  output logic [CNT_W-1:0]               Stall_Count,
  output logic                           Done,
  output logic                           Pass,
  output logic                           Timeout,
  output logic [31:0]                    Exit_Code,
  output logic [31:0]                    Trace_PC
);

  localparam int unsigned IDX_W   = $clog2(TRACE_DEPTH);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   fetch_q, fetch_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        exit_q, exit_d;

  logic [CNT_W-1:0]   cycle_inc;
  logic               mailbox_hit;
  logic               timeout_hit;
  logic               halt_hit;
  logic               trace_we;

  // Saturating increment shared by all performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State and result registers; synchronous reset clears everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      cycle_q   <= '0;
      fetch_q   <= '0;
      stall_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      exit_q    <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      fetch_q   <= fetch_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      exit_q    <= exit_d;
    end
  end

  // Next-state, counter and verdict logic; end events resolved by priority.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_d     = cycle_q;
    fetch_d     = fetch_q;
    stall_d     = stall_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_d      = exit_q;
    trace_we    = 1'b0;

    cycle_inc   = sat_inc(cycle_q);
    mailbox_hit = MemWrite_MEM && (ALU_Result_MEM == TOHOST_ADDR);
    timeout_hit = (cycle_inc == CNT_W'(TIMEOUT_CYCLES));
    halt_hit    = PC_Enable && (Instruction_IF == HALT_INSN);

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        // The terminating cycle is still counted.
        cycle_d  = cycle_inc;
        trace_we = PC_Enable;
        if (PC_Enable) fetch_d = sat_inc(fetch_q);
        else           stall_d = sat_inc(stall_q);

        if (mailbox_hit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          exit_d    = Write_Data_MUX_MEM;
          pass_d    = (Write_Data_MUX_MEM == 32'd1);
          timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          exit_d    = '0;
        end else if (state_q == ST_RUN) begin
          if (halt_hit) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
              exit_d  = '0;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end else begin
          // DRAIN: halt fetches ignored; retire after the counter runs out.
          if (drain_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            exit_d  = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  assign Cycle_Count = cycle_q;
  assign Fetch_Count = fetch_q;
  assign Stall_Count = stall_q;
  assign Done        = done_q;
  assign Pass        = pass_q;
  assign Timeout     = timeout_q;
  assign Exit_Code   = exit_q;

`ifdef MON_TRACE_EN
  logic [31:0]      trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wptr_q;
  logic [IDX_W-1:0] rd_idx;

  // Circular PC trace; pointer wraps naturally since depth is a power of 2.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr_q <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
    end else if (trace_we) begin
      trace_mem[wptr_q] <= Next_PC_IF;
      wptr_q            <= wptr_q + IDX_W'(1);
    end
  end

  // Index 0 selects the most recent entry.
  always_comb begin
    rd_idx   = wptr_q - IDX_W'(1) - Trace_Idx;
    Trace_PC = trace_mem[rd_idx];
  end
`else
  logic unused_trace;

  // No trace buffer: readout is tied low and the trace inputs are unused.
  always_comb begin
    unused_trace = ^{Trace_Idx, Next_PC_IF, trace_we};
    Trace_PC     = '0;
  end
`endif

endmodule
